// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped N-pin GPIO controller with per-pin direction, atomic
// set/clear/toggle of outputs and synchronised edge-detect level interrupt.
module gpio_bank #(
    parameter int          N_PINS      = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              WE,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [3:0] OFF_OUT  = 4'd0;
    localparam logic [3:0] OFF_DIR  = 4'd1;
    localparam logic [3:0] OFF_IN   = 4'd2;
    localparam logic [3:0] OFF_SET  = 4'd3;
    localparam logic [3:0] OFF_CLR  = 4'd4;
    localparam logic [3:0] OFF_TGL  = 4'd5;
    localparam logic [3:0] OFF_RISE = 4'd6;
    localparam logic [3:0] OFF_FALL = 4'd7;
    localparam logic [3:0] OFF_IRQ  = 4'd8;

    localparam logic [N_PINS-1:0] PINS_ZERO = {N_PINS{1'b0}};

    logic [N_PINS-1:0] out_r;
    logic [N_PINS-1:0] dir_r;
    logic [N_PINS-1:0] rise_en_r;
    logic [N_PINS-1:0] fall_en_r;
    logic [N_PINS-1:0] irq_stat_r;
    logic [N_PINS-1:0] prev_r;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_r;

    logic              hit_s;
    logic [3:0]        offset_s;
    logic [N_PINS-1:0] wd_s;
    logic [N_PINS-1:0] in_s;
    logic [N_PINS-1:0] rise_s;
    logic [N_PINS-1:0] fall_s;
    logic [N_PINS-1:0] out_nxt_s;
    logic [N_PINS-1:0] dir_nxt_s;
    logic [N_PINS-1:0] rise_en_nxt_s;
    logic [N_PINS-1:0] fall_en_nxt_s;
    logic [N_PINS-1:0] w1c_s;
    logic [N_PINS-1:0] irq_stat_nxt_s;
    logic              unused_s;

    assign hit_s    = (A[31:6] == BASE_ADDR[31:6]);
    assign offset_s = A[5:2];
    assign wd_s     = WD[N_PINS-1:0];
    assign unused_s = ^{A[1:0], WD};

    assign in_s   = sync_r[SYNC_STAGES-1];
    assign rise_s = in_s & ~prev_r & rise_en_r;
    assign fall_s = ~in_s & prev_r & fall_en_r;

    // A fresh edge must survive a same-cycle write-1-to-clear of its bit.
    assign irq_stat_nxt_s = (irq_stat_r & ~w1c_s) | rise_s | fall_s;

    assign gpio_out = out_r;
    assign gpio_oe  = dir_r;
    assign irq      = |irq_stat_r;

    // Bus write decode: next values of the software-visible registers.
    always_comb begin
        out_nxt_s     = out_r;
        dir_nxt_s     = dir_r;
        rise_en_nxt_s = rise_en_r;
        fall_en_nxt_s = fall_en_r;
        w1c_s         = PINS_ZERO;
        if (WE && hit_s) begin
            case (offset_s)
                OFF_OUT:  out_nxt_s     = wd_s;
                OFF_DIR:  dir_nxt_s     = wd_s;
                OFF_SET:  out_nxt_s     = out_r | wd_s;
                OFF_CLR:  out_nxt_s     = out_r & ~wd_s;
                OFF_TGL:  out_nxt_s     = out_r ^ wd_s;
                OFF_RISE: rise_en_nxt_s = wd_s;
                OFF_FALL: fall_en_nxt_s = wd_s;
                OFF_IRQ:  w1c_s         = wd_s;
                default:  w1c_s         = PINS_ZERO;
            endcase
        end else begin
            w1c_s = PINS_ZERO;
        end
    end

    // Read mux; write-only strobes and unmapped offsets read as zero.
    always_comb begin
        RD = 32'd0;
        if (hit_s) begin
            case (offset_s)
                OFF_OUT:  RD[N_PINS-1:0] = out_r;
                OFF_DIR:  RD[N_PINS-1:0] = dir_r;
                OFF_IN:   RD[N_PINS-1:0] = in_s;
                OFF_RISE: RD[N_PINS-1:0] = rise_en_r;
                OFF_FALL: RD[N_PINS-1:0] = fall_en_r;
                OFF_IRQ:  RD[N_PINS-1:0] = irq_stat_r;
                default:  RD = 32'd0;
            endcase
        end else begin
            RD = 32'd0;
        end
    end

    // Register, synchroniser and edge-history update.
    always_ff @(posedge CLK) begin
        if (reset) begin
            out_r      <= PINS_ZERO;
            dir_r      <= PINS_ZERO;
            rise_en_r  <= PINS_ZERO;
            fall_en_r  <= PINS_ZERO;
            irq_stat_r <= PINS_ZERO;
            prev_r     <= PINS_ZERO;
            sync_r     <= {(SYNC_STAGES*N_PINS){1'b0}};
        end else begin
            out_r      <= out_nxt_s;
            dir_r      <= dir_nxt_s;
            rise_en_r  <= rise_en_nxt_s;
            fall_en_r  <= fall_en_nxt_s;
            irq_stat_r <= irq_stat_nxt_s;
            prev_r     <= in_s;
            sync_r[0]  <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO controller replacing the single-pin GPIO peripheral on the processor's memory stage. It has N_PINS bidirectional pins, with per-pin direction and atomic set/clear/toggle of outputs. Inputs pass through a synchroniser and feed per-pin rising/falling edge detection, which drives a level interrupt. It decodes the same A/WD/WE/RD data-side bus used by the data memory, UART and GPIO, at its own base address.

## Interface

Parameters:
- N_PINS, 8, number of pins (1..32); register bits [31:N_PINS] read 0, writes to them ignored
- BASE_ADDR, 32'h8000_0100, word-aligned base of a 64-byte window; must not overlap the UART or legacy GPIO addresses
- SYNC_STAGES, 2, input synchroniser depth (≥2)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- WE  in  1  write strobe (MemWriteM qualified by address decode upstream)
- A  in  32  byte address; A[1:0] ignored
- WD  in  32  write data
- RD  out  32  read data, combinational from A and current register state
- gpio_in  in  N_PINS  asynchronous pin inputs
- gpio_out  out  N_PINS  output data register
- gpio_oe  out  N_PINS  output enable (= DIR)
- irq  out  1  level interrupt, OR of (IRQ_STAT) bits

## Operation

- Hit when A[31:6] == BASE_ADDR[31:6]; offset = A[5:2]. Writes outside the window or with WE=0 have no effect. RD = 0 on a miss or an unmapped offset.
- Register map (word offset):
  - 0x00 OUT: rw.
  - 0x04 DIR: rw; 1 = drive.
  - 0x08 IN: ro; synchroniser output.
  - 0x0C SET: wo; OUT |= WD. Reads 0.
  - 0x10 CLR: wo; OUT &= ~WD. Reads 0.
  - 0x14 TGL: wo; OUT ^= WD. Reads 0.
  - 0x18 RISE_EN: rw.
  - 0x1C FALL_EN: rw.
  - 0x20 IRQ_STAT: read; write-1-to-clear.
- Synchroniser: SYNC_STAGES flops per pin; IN = last stage. Edge detect uses a history flop prev <= IN.
  - rise = IN & ~prev & RISE_EN
  - fall = ~IN & prev & FALL_EN
- IRQ_STAT next = (IRQ_STAT & ~(w1c_mask)) | rise | fall. A new edge in the same cycle as a W1C of that bit wins (bit stays 1).
- Pins are sampled regardless of DIR; an output pin looped back externally produces edges.
- Clearing RISE_EN/FALL_EN does not clear already-set IRQ_STAT bits.
- irq = |IRQ_STAT[N_PINS-1:0], combinational from the register.

## Timing

- Reset (synchronous, reset=1 at edge): OUT, DIR, RISE_EN, FALL_EN, IRQ_STAT, all sync and prev flops → 0. Hence gpio_out=0, gpio_oe=0, irq=0, RD=0 at every offset except those reading zeroed registers.
- Register writes: visible on RD and on gpio_out/gpio_oe one cycle after the WE edge.
- Input path: pin change before edge k → IN updated after edge k+SYNC_STAGES-1 → IRQ_STAT/irq set after edge k+SYNC_STAGES.
- Pin held high across reset release: no interrupt, because enables are 0. If RISE_EN is later set while the pin is stable high, no event (prev==IN).
- Reset asserted mid-pulse: all history is lost; the first post-reset sample is compared against prev=0.
- Zero-wait bus: no handshake; every access completes in the cycle presented.

## Test plan

- Reset, then read offsets 0x00–0x20 → all 0; irq=0, gpio_out=0, gpio_oe=0.
- Write DIR=0xFF, OUT=0xA5, SET=0x0A, CLR=0x81, TGL=0x0F → gpio_out sequence A5, AF, 2E, 21; each takes effect 1 cycle after its write; reads of SET/CLR/TGL return 0.
- RISE_EN=0x01, drive gpio_in[0] 0→1 before edge k → IN[0]=1 after edge k+1, IRQ_STAT=0x01 and irq=1 after edge k+2. Write 0x01 to IRQ_STAT → irq=0 next cycle.
- FALL_EN=0x80, pulse gpio_in[7] high 5 cycles then low → only the falling edge sets bit 7; RISE_EN=0 suppresses the rising edge.
- Same-cycle W1C of bit 0 and new rising edge on pin 0 → IRQ_STAT[0] remains 1.
- N_PINS=4: write OUT=0xFFFF_FFFF → read 0x0000_000F. Access at BASE_ADDR+0x40 or an unmapped offset → no state change, RD=0.
